// File: rtl/nios_system_led_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module   : nios_system_led_pulse_pio
//  Purpose  : Output-direction Avalon-MM PIO slave. Drives WIDTH output pins
//             from a data register with atomic set/clear, plus a hardware
//             one-shot pulse that ORs a mask onto the pins for a programmable
//             number of cycles and raises a maskable done interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module nios_system_led_pulse_pio #(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  // Register word addresses
  localparam logic [2:0] C_ADDR_DATA   = 3'd0;
  localparam logic [2:0] C_ADDR_LEN    = 3'd1;
  localparam logic [2:0] C_ADDR_GO     = 3'd2;
  localparam logic [2:0] C_ADDR_STATUS = 3'd3;
  localparam logic [2:0] C_ADDR_OUTSET = 3'd4;
  localparam logic [2:0] C_ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] C_ADDR_IRQEN  = 3'd6;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_PULSE = 1'b1
  } state_t;

  // Bus decode
  logic             w_write;
  logic [WIDTH-1:0] w_wr_bits;
  logic [CNT_W-1:0] w_wr_len;
  logic             w_go;
  logic             w_status_wr;

  // Registers
  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_len;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_irq_en;
  logic [31:0]      r_readdata;

  // Next-state / combinational helpers
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_mask_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done_set;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_busy;
  logic [31:0]      w_rd_mux;

  assign w_write     = chipselect & ~write_n;
  assign w_wr_bits   = writedata[WIDTH-1:0];
  assign w_wr_len    = writedata[CNT_W-1:0];
  // A GO with an all-zero mask is treated as if it never happened
  assign w_go        = w_write && (address == C_ADDR_GO) && (|w_wr_bits);
  assign w_status_wr = w_write && (address == C_ADDR_STATUS);

  // A programmed length of 0 still produces a single-cycle pulse
  assign w_len_eff   = (r_len == '0) ? C_CNT_ONE : r_len;
  assign w_busy      = (r_state == S_PULSE);

  // Data register: direct write, atomic set, atomic clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_write) begin
      case (address)
        C_ADDR_DATA:   r_data <= w_wr_bits;
        C_ADDR_OUTSET: r_data <= r_data | w_wr_bits;
        C_ADDR_OUTCLR: r_data <= r_data & ~w_wr_bits;
        default:       r_data <= r_data;
      endcase
    end
  end

  // Pulse length and interrupt enable configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len    <= '0;
      r_irq_en <= 1'b0;
    end else if (w_write) begin
      if (address == C_ADDR_LEN)   r_len    <= w_wr_len;
      if (address == C_ADDR_IRQEN) r_irq_en <= writedata[0];
    end
  end

  // Pulse FSM next state: start/retrigger on GO, count down, finish at 1
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_PULSE;
          w_mask_nxt  = w_wr_bits;
          w_cnt_nxt   = w_len_eff;
        end
      end
      S_PULSE: begin
        if (w_go) begin
          // Retrigger: the aborted pulse never reports done
          w_mask_nxt = w_wr_bits;
          w_cnt_nxt  = w_len_eff;
        end else if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_mask_nxt  = '0;
          w_cnt_nxt   = '0;
          w_done_set  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pulse FSM state, mask and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sticky done flag; completion beats a coincident STATUS clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else if (w_done_set) begin
      r_done <= 1'b1;
    end else if (w_status_wr) begin
      r_done <= 1'b0;
    end
  end

  // Read mux; every field zero-extended to the 32-bit bus
  always_comb begin
    w_rd_mux = '0;
    case (address)
      C_ADDR_DATA:   w_rd_mux[WIDTH-1:0] = r_data;
      C_ADDR_LEN:    w_rd_mux[CNT_W-1:0] = r_len;
      C_ADDR_GO:     w_rd_mux[WIDTH-1:0] = r_mask;
      C_ADDR_STATUS: w_rd_mux[1:0]       = {w_busy, r_done};
      C_ADDR_IRQEN:  w_rd_mux[0]         = r_irq_en;
      default:       w_rd_mux            = '0;
    endcase
  end

  // Registered read data, updated every cycle independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  // Pulse mask is cleared whenever idle, so a plain OR is safe here
  assign out_port = r_data | r_mask;
  assign irq      = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_led_pulse_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios_system_led_pulse_pio
//  Purpose  : Self-checking bench for nios_system_led_pulse_pio. Vector table,
//             directed pulse sequences and random traffic against a
//             deadline-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_led_pulse_pio;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 8;
  localparam logic [7:0] RV    = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  out_port;

  int checks = 0;
  int failures = 0;

  nios_system_led_pulse_pio #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model: pulse tracked as an absolute deadline in cycles
  int         cyc;
  logic [7:0] m_data, m_len, m_mask;
  logic       m_irqen, m_busy, m_done;
  int         m_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = RV; m_len = 0; m_mask = 0; m_irqen = 0; m_busy = 0; m_done = 0; m_end = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_data};
      3'd1: return {24'h0, m_len};
      3'd2: return {24'h0, m_mask};
      3'd3: return {30'h0, m_busy, m_done};
      3'd6: return {31'h0, m_irqen};
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, clock, update model, compare all outputs
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        we, compl, clr;
    exp_rd = model_read(a);
    we = cs & ~wn;
    chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    cyc++;
    compl = m_busy && (cyc == m_end);
    if (compl) begin m_busy = 0; m_mask = 0; end
    clr = 0;
    if (we) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_len = d[7:0];
        3'd2: if (d[7:0] != 0) begin
                m_busy = 1; m_mask = d[7:0];
                m_end = cyc + ((m_len == 0) ? 1 : int'(m_len));
                compl = 0;
              end
        3'd3: clr = 1;
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        3'd6: m_irqen = d[0];
        default: ;
      endcase
    end
    if (compl) m_done = 1;
    else if (clr) m_done = 0;
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("model_out_port", {24'h0, out_port}, {24'h0, m_data | m_mask});
    chk("model_irq", {31'h0, irq}, {31'h0, m_done & m_irqen});
    chk("model_readdata", readdata, exp_rd);
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  exp_out;
    logic        exp_irq;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h0,        8'hA5, 1'b0, 32'hA5};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd7, 32'h0,        8'hA5, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'd0, 32'h0000000F, 8'h0F, 1'b0, 32'hA5};
    vecs[9]  = '{1'b1, 3'd4, 32'h00000030, 8'h3F, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'd5, 32'h00000001, 8'h3E, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd0, 32'h0,        8'h3E, 1'b0, 32'h3E};
    vecs[12] = '{1'b1, 3'd1, 32'h00000105, 8'h3E, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'd1, 32'h0,        8'h3E, 1'b0, 32'h05};
    vecs[14] = '{1'b1, 3'd6, 32'hFFFFFFFF, 8'h3E, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'd6, 32'h0,        8'h3E, 1'b0, 32'h1};
    vecs[16] = '{1'b1, 3'd7, 32'hFFFFFFFF, 8'h3E, 1'b0, 32'h0};

    cyc = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_out_port", {24'h0, out_port}, {24'h0, RV});
    chk("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].we, ~vecs[i].we, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // Five-cycle pulse on bit7 (len=5, irq_en=1 from the table)
    step(1, 0, 3'd2, 32'h80);
    chk("a_bit7_k1", {31'h0, out_port[7]}, 32'h1);
    for (int k = 2; k <= 7; k++) begin
      step(1, 1, 3'd3, 32'h0);
      chk($sformatf("a_bit7_k%0d", k), {31'h0, out_port[7]}, {31'h0, (k <= 5)});
      chk($sformatf("a_irq_k%0d", k), {31'h0, irq}, {31'h0, (k >= 6)});
      if (k == 2) chk("a_status_busy", readdata, 32'h2);
      if (k == 7) chk("a_status_done", readdata, 32'h1);
    end

    // Length 0 gives one cycle; completion wins over coincident clear
    step(1, 0, 3'd3, 32'h0);
    chk("b_irq_cleared", {31'h0, irq}, 32'h0);
    step(1, 0, 3'd1, 32'h0);
    step(1, 0, 3'd2, 32'h03);
    chk("b_out_pulse", {24'h0, out_port}, 32'h3F);
    step(1, 0, 3'd3, 32'h0);
    chk("b_done_kept", {31'h0, irq}, 32'h1);
    chk("b_out_after", {24'h0, out_port}, 32'h3E);
    step(1, 0, 3'd3, 32'h0);
    chk("b_done_clear", {31'h0, irq}, 32'h0);

    // Retrigger with a new mask; zero-mask GO ignored mid-pulse
    step(1, 0, 3'd0, 32'h0);
    step(1, 0, 3'd1, 32'd10);
    step(1, 0, 3'd2, 32'h02);
    for (int k = 2; k <= 17; k++) begin
      if (k == 5)      step(1, 0, 3'd2, 32'h04);
      else if (k == 9) step(1, 0, 3'd2, 32'h00);
      else             step(1, 1, 3'd3, 32'h0);
      chk($sformatf("c_bit1_k%0d", k), {31'h0, out_port[1]}, {31'h0, (k <= 4)});
      chk($sformatf("c_bit2_k%0d", k), {31'h0, out_port[2]}, {31'h0, (k >= 5 && k <= 14)});
      chk($sformatf("c_irq_k%0d", k), {31'h0, irq}, {31'h0, (k >= 15)});
    end
    step(1, 0, 3'd3, 32'h0);

    // Reset asserted mid-pulse
    step(1, 0, 3'd0, 32'h0F);
    step(1, 0, 3'd1, 32'd100);
    step(1, 0, 3'd2, 32'h10);
    repeat (19) step(1, 1, 3'd3, 32'h0);
    chk("d_pulse_on", {24'h0, out_port}, 32'h1F);
    #3 reset_n = 1'b0;
    #1;
    chk("d_async_out", {24'h0, out_port}, {24'h0, RV});
    chk("d_async_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    chk("d_rd_after_reset", readdata, 32'h0);
    step(1, 1, 3'd3, 32'h0);
    step(1, 1, 3'd2, 32'h0);
    chk("d_status_clear", readdata, 32'h0);

    // Random traffic against the model
    step(1, 0, 3'd6, 32'h1);
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      logic        cs, wn;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) != 0);
      d  = $urandom;
      if (a == 3'd1 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 6);
      if (a == 3'd2 && $urandom_range(0, 3) == 0) d = 32'hFFFFFF00;
      step(cs, wn, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
